// File: rtl/mips_pkg.sv
// Shared opcode/ALUOp constants, FSM state type and per-state control decode.
// MULTICYCLE_CTRL_BEQ_EN enables the BRANCH state's controls.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC_R,
        WB_R,
        EXEC_MEM,
        MEM_RD,
        WB_LW,
        MEM_WR,
        BRANCH,
        ERROR
    } state_t;

    typedef struct packed {
        logic       instr_ready;
        logic       ir_write;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] alu_op;
        logic       done;
        logic       illegal;
    } ctrl_t;

    // Control word for a state; last marks the final MEM_WR cycle.
    function automatic ctrl_t ctrl_of(input state_t s, input logic last);
        ctrl_t c;
        c = '0;
        case (s)
            IDLE:     c.instr_ready = 1'b1;
            FETCH: begin
                c.ir_write = 1'b1;
                c.pc_write = 1'b1;
            end
            EXEC_R:   c.alu_op = ALUOP_FUNCT;
            WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.done      = 1'b1;
            end
            EXEC_MEM: begin
                c.alu_op  = ALUOP_ADD;
                c.alu_src = 1'b1;
            end
            MEM_RD:   c.mem_read = 1'b1;
            WB_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.done       = 1'b1;
            end
            MEM_WR: begin
                c.mem_write = 1'b1;
                c.done      = last;
            end
`ifdef MULTICYCLE_CTRL_BEQ_EN
            BRANCH: begin
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.done          = 1'b1;
            end
`endif
            ERROR:    c.illegal = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction handshake and datapath control strobes between controller and datapath.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       newinstr;
    logic       instr_ready;
    logic       ir_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] alu_op;
    logic       done;
    logic       illegal;

    modport master (
        output opcode, newinstr,
        input  instr_ready, ir_write, reg_dst, alu_src, mem_to_reg, reg_write,
               mem_read, mem_write, pc_write, pc_write_cond, alu_op, done, illegal
    );

    modport slave (
        input  opcode, newinstr,
        output instr_ready, ir_write, reg_dst, alu_src, mem_to_reg, reg_write,
               mem_read, mem_write, pc_write, pc_write_cond, alu_op, done, illegal
    );
endinterface

// File: rtl/mem_wait_counter.sv
// Saturating down-counter timing the data-memory access states.
// zero_next looks one edge ahead so the FSM can register a last-cycle strobe.
module mem_wait_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero,
    output logic       zero_next
);
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (load)
            cnt_nxt = load_val;
        else if (cnt != 4'd0)
            cnt_nxt = cnt - 4'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= 4'd0;
        else
            cnt <= cnt_nxt;
    end

    assign zero      = (cnt == 4'd0);
    assign zero_next = (cnt_nxt == 4'd0);
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM (R-type, lw, sw, optional beq) with registered Moore outputs.
// Define MULTICYCLE_CTRL_BEQ_EN to support opcode 4; otherwise it decodes as illegal.
//
//  state    | meaning
//  IDLE     | ready for a new instruction
//  FETCH    | load IR, advance PC
//  DECODE   | dispatch on latched opcode
//  EXEC_R   | ALU op from funct
//  WB_R     | write ALU result to rd
//  EXEC_MEM | compute address base+imm
//  MEM_RD   | memory read, MEM_LAT cycles
//  WB_LW    | write load data to rt
//  MEM_WR   | memory write, MEM_LAT cycles
//  BRANCH   | compare and conditional PC write
//  ERROR    | unsupported opcode, one cycle
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input logic            clock,
    input logic            reset,
    multicycle_ctrl_if.slave bus
);
    localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT - 1);

    state_t     state;
    logic [5:0] op_q;
    ctrl_t      ctrl;
    logic       wait_load;
    logic       wait_zero;
    logic       wait_zero_next;

    function automatic state_t dispatch(input logic [5:0] op);
        state_t s;
        case (op)
            OP_RTYPE:     s = EXEC_R;
            OP_LW, OP_SW: s = EXEC_MEM;
`ifdef MULTICYCLE_CTRL_BEQ_EN
            OP_BEQ:       s = BRANCH;
`endif
            default:      s = ERROR;
        endcase
        return s;
    endfunction

    assign wait_load = (state == EXEC_MEM);

    mem_wait_counter u_wait (
        .clock     (clock),
        .reset     (reset),
        .load      (wait_load),
        .load_val  (WAIT_INIT),
        .zero      (wait_zero),
        .zero_next (wait_zero_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            op_q  <= 6'd0;
            ctrl  <= ctrl_of(IDLE, 1'b0);
        end else begin
            case (state)
                IDLE: if (bus.newinstr) begin
                    state <= FETCH;
                    op_q  <= bus.opcode;
                    ctrl  <= ctrl_of(FETCH, 1'b0);
                end
                FETCH: begin
                    state <= DECODE;
                    ctrl  <= ctrl_of(DECODE, 1'b0);
                end
                DECODE: begin
                    state <= dispatch(op_q);
                    ctrl  <= ctrl_of(dispatch(op_q), 1'b0);
                end
                EXEC_R: begin
                    state <= WB_R;
                    ctrl  <= ctrl_of(WB_R, 1'b0);
                end
                EXEC_MEM: begin
                    state <= (op_q == OP_LW) ? MEM_RD : MEM_WR;
                    ctrl  <= ctrl_of((op_q == OP_LW) ? MEM_RD : MEM_WR, wait_zero_next);
                end
                MEM_RD: if (wait_zero) begin
                    state <= WB_LW;
                    ctrl  <= ctrl_of(WB_LW, 1'b0);
                end
                MEM_WR: begin
                    if (wait_zero) begin
                        state <= IDLE;
                        ctrl  <= ctrl_of(IDLE, 1'b0);
                    end else begin
                        ctrl  <= ctrl_of(MEM_WR, wait_zero_next);
                    end
                end
                default: begin
                    state <= IDLE;
                    ctrl  <= ctrl_of(IDLE, 1'b0);
                end
            endcase
        end
    end

    // pc_write_cond is constant 0 when beq support is compiled out.
    assign bus.instr_ready   = ctrl.instr_ready;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.alu_src       = ctrl.alu_src;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.done          = ctrl.done;
    assign bus.illegal       = ctrl.illegal;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl with MEM_LAT=3.
module tb_multicycle_ctrl;
    localparam int LAT = 3;

    localparam logic [13:0] B_RDY  = 14'h2000;
    localparam logic [13:0] B_IRW  = 14'h1000;
    localparam logic [13:0] B_DST  = 14'h0800;
    localparam logic [13:0] B_SRC  = 14'h0400;
    localparam logic [13:0] B_M2R  = 14'h0200;
    localparam logic [13:0] B_RW   = 14'h0100;
    localparam logic [13:0] B_MRD  = 14'h0080;
    localparam logic [13:0] B_MWR  = 14'h0040;
    localparam logic [13:0] B_PCW  = 14'h0020;
    localparam logic [13:0] B_PCC  = 14'h0010;
    localparam logic [13:0] A_SUB  = 14'h0004;
    localparam logic [13:0] A_FUN  = 14'h0008;
    localparam logic [13:0] B_DONE = 14'h0002;
    localparam logic [13:0] B_ILL  = 14'h0001;

    typedef struct {
        logic [13:0] vec;
        string       tag;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_LAT(LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [13:0] obs();
        return {bus.instr_ready, bus.ir_write, bus.reg_dst, bus.alu_src, bus.mem_to_reg,
                bus.reg_write, bus.mem_read, bus.mem_write, bus.pc_write, bus.pc_write_cond,
                bus.alu_op, bus.done, bus.illegal};
    endfunction

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] want);
        n_checks++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, want);
        end
    endtask

    task automatic push(input logic [13:0] v, input string t);
        exp_t e;
        e.vec = v;
        e.tag = t;
        exp_q.push_back(e);
    endtask

    // Expected per-cycle controls from acceptance to the following IDLE cycle.
    task automatic expect_instr(input logic [5:0] op, input string name);
        push(B_IRW | B_PCW, {name, " fetch"});
        push(14'h0, {name, " decode"});
        case (op)
            6'd0: begin
                push(A_FUN, {name, " exec_r"});
                push(B_RW | B_DST | B_DONE, {name, " wb_r"});
            end
            6'd35: begin
                push(B_SRC, {name, " exec_mem"});
                for (int i = 0; i < LAT; i++) push(B_MRD, {name, " mem_rd"});
                push(B_RW | B_M2R | B_DONE, {name, " wb_lw"});
            end
            6'd43: begin
                push(B_SRC, {name, " exec_mem"});
                for (int i = 0; i < LAT - 1; i++) push(B_MWR, {name, " mem_wr"});
                push(B_MWR | B_DONE, {name, " mem_wr_last"});
            end
`ifdef MULTICYCLE_CTRL_BEQ_EN
            6'd4: push(A_SUB | B_PCC | B_DONE, {name, " branch"});
`endif
            default: push(B_ILL, {name, " error"});
        endcase
        push(B_RDY, {name, " idle"});
    endtask

    // Called just after a falling edge; the next rising edge accepts.
    task automatic run_instr(input logic [5:0] op, input string name, input bit hold);
        int   cyc;
        exp_t e;
        expect_instr(op, name);
        bus.opcode   = op;
        bus.newinstr = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            e = exp_q.pop_front();
            cyc++;
            check($sformatf("%s c%0d", e.tag, cyc), obs(), e.vec);
            if (!hold) bus.newinstr = 1'b0;
            if (hold && cyc == 4) bus.opcode = 6'd0;
        end
        bus.newinstr = 1'b0;
    endtask

    initial begin
        bus.opcode   = 6'd0;
        bus.newinstr = 1'b0;

        repeat (3) begin
            @(negedge clock);
            check("reset hold", obs(), B_RDY);
        end
        reset = 1'b1;
        run_instr(6'd0,  "rtype", 1'b0);
        run_instr(6'd35, "lw", 1'b0);
        run_instr(6'd43, "sw", 1'b0);
        run_instr(6'd4,  "beq", 1'b0);
        run_instr(6'd63, "op63", 1'b0);
        run_instr(6'd35, "lw_hold", 1'b1);

        // Abort a lw in EXEC_MEM with an asynchronous reset pulse.
        bus.opcode   = 6'd35;
        bus.newinstr = 1'b1;
        @(negedge clock);
        check("abort fetch", obs(), B_IRW | B_PCW);
        bus.newinstr = 1'b0;
        @(negedge clock);
        check("abort decode", obs(), 14'h0);
        @(negedge clock);
        check("abort exec_mem", obs(), B_SRC);
        #2 reset = 1'b0;
        #1 check("abort async", obs(), B_RDY);
        @(negedge clock);
        check("abort held", obs(), B_RDY);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clock);
            check("abort no done", obs(), B_RDY);
        end

        run_instr(6'd43, "sw_after", 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
